// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
// This package holds the FSM state encoding, the requester port indices
// and a small helper that turns a port index into a one-hot vector.
package dmem_arb_pkg;

   // Three-state access sequencer: pick a winner, strobe memory, report.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   // Requester indices: bit 0 is the CPU, bit 1 is the loader/DMA.
   localparam int PORT_CPU  = 0;
   localparam int PORT_DMA  = 1;
   localparam int NUM_PORTS = 2;

   // Expands a single-bit port index into the one-hot form used by gnt/rvalid.
   function automatic logic [NUM_PORTS-1:0] portOneHot(input logic port);
      logic [NUM_PORTS-1:0] oneHot;
      oneHot = '0;
      if (port) begin
         oneHot[PORT_DMA] = 1'b1;
      end else begin
         oneHot[PORT_CPU] = 1'b1;
      end
      return oneHot;
   endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way round-robin winner selection.
// A lone requester always wins. When both request, the port that did not
// win last time gets the grant, so neither side can starve the other.
module dmem_rr_pick
   import dmem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] win
);

   // Pure combinational pick; 'last' is the index of the previous winner.
   always_comb begin
      win = 2'b00;
      case (req)
         2'b01: win[PORT_CPU] = 1'b1;
         2'b10: win[PORT_DMA] = 1'b1;
         2'b11: begin
            if (last == 1'(PORT_CPU)) begin
               win[PORT_DMA] = 1'b1;
            end else begin
               win[PORT_CPU] = 1'b1;
            end
         end
         default: win = 2'b00;
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the CPU and the loader/DMA port.
// Each access takes a fixed two cycles: a grant cycle in which the memory
// is strobed (ACCESS) followed by a completion cycle (RESP). Requests seen
// in RESP are granted immediately, giving one access every two cycles when
// loaded. Misaligned or out-of-range addresses never strobe the memory and
// complete with err_o set and zero read data. All outputs are registered and
// cleared by the asynchronous reset, which also kills an in-flight store.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int MEM_BYTES = 1024,
   parameter int CNT_W     = 16
)(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [1:0]       req_i,
   input  logic [1:0]       we_i,
   input  logic [31:0]      addr0_i,
   input  logic [31:0]      addr1_i,
   input  logic [31:0]      wdata0_i,
   input  logic [31:0]      wdata1_i,
   output logic [1:0]       gnt_o,
   output logic [1:0]       rvalid_o,
   output logic [31:0]      rdata_o,
   output logic             err_o,
   output logic [31:0]      mem_addr_o,
   output logic [31:0]      mem_data_o,
   output logic             mem_read_o,
   output logic             mem_write_o,
   input  logic [31:0]      mem_data_i,
   output logic [CNT_W-1:0] acc_cnt_o
);

   // Highest byte address at which a full word still fits in the memory.
   localparam logic [31:0] LAST_WORD_ADDR = 32'(MEM_BYTES - 4);

   state_t           r_state;
   logic             r_last;
   logic             r_port;
   logic             r_we;
   logic             r_err;
   logic [31:0]      r_addr;
   logic [31:0]      r_wdata;
   logic [1:0]       r_gnt;
   logic [1:0]       r_rvalid;
   logic [31:0]      r_rdata;
   logic             r_errOut;
   logic             r_memRead;
   logic             r_memWrite;
   logic [CNT_W-1:0] r_cnt;

   logic [1:0]       w_win;
   logic             w_anyReq;
   logic             w_winPort;
   logic             w_selWe;
   logic [31:0]      w_selAddr;
   logic [31:0]      w_selWdata;
   logic             w_selErr;
   logic             w_cntFull;

   dmem_rr_pick u_pick (
      .req  (req_i),
      .last (r_last),
      .win  (w_win)
   );

   assign w_anyReq   = |req_i;
   assign w_winPort  = w_win[PORT_DMA];
   assign w_selWe    = w_winPort ? we_i[PORT_DMA] : we_i[PORT_CPU];
   assign w_selAddr  = w_winPort ? addr1_i  : addr0_i;
   assign w_selWdata = w_winPort ? wdata1_i : wdata0_i;
   assign w_selErr   = (w_selAddr[1:0] != 2'b00) || (w_selAddr > LAST_WORD_ADDR);
   assign w_cntFull  = &r_cnt;

   // Sequencer: latch the winning command, strobe memory, then report completion.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state    <= IDLE;
         r_last     <= 1'(PORT_DMA);
         r_port     <= 1'b0;
         r_we       <= 1'b0;
         r_err      <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_gnt      <= '0;
         r_rvalid   <= '0;
         r_rdata    <= '0;
         r_errOut   <= 1'b0;
         r_memRead  <= 1'b0;
         r_memWrite <= 1'b0;
         r_cnt      <= '0;
      end else begin
         case (r_state)
            IDLE, RESP: begin
               r_rvalid <= '0;
               r_errOut <= 1'b0;
               if (w_anyReq) begin
                  r_port     <= w_winPort;
                  r_we       <= w_selWe;
                  r_addr     <= w_selAddr;
                  r_wdata    <= w_selWdata;
                  r_err      <= w_selErr;
                  r_gnt      <= w_win;
                  r_last     <= w_winPort;
                  r_memRead  <= !w_selErr && !w_selWe;
                  r_memWrite <= !w_selErr && w_selWe;
                  r_state    <= ACCESS;
               end else begin
                  r_gnt   <= '0;
                  r_state <= IDLE;
               end
            end
            ACCESS: begin
               r_gnt      <= '0;
               r_memRead  <= 1'b0;
               r_memWrite <= 1'b0;
               r_rvalid   <= portOneHot(r_port);
               r_errOut   <= r_err;
               if (r_err) begin
                  r_rdata <= '0;
               end else if (!r_we) begin
                  r_rdata <= mem_data_i;
               end
               if (!w_cntFull) begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
               r_state <= RESP;
            end
            default: begin
               r_gnt      <= '0;
               r_rvalid   <= '0;
               r_errOut   <= 1'b0;
               r_memRead  <= 1'b0;
               r_memWrite <= 1'b0;
               r_state    <= IDLE;
            end
         endcase
      end
   end

   assign gnt_o       = r_gnt;
   assign rvalid_o    = r_rvalid;
   assign rdata_o     = r_rdata;
   assign err_o       = r_errOut;
   assign mem_addr_o  = r_addr;
   assign mem_data_o  = r_wdata;
   assign mem_read_o  = r_memRead;
   assign mem_write_o = r_memWrite;
   assign acc_cnt_o   = r_cnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter.
// A word-addressed memory model sits on the memory port. A shadow copy of
// that memory predicts load data; every issued access pushes its expected
// completion (port, error, data, cycle) onto a queue that the completion
// monitor pops whenever rvalid_o pulses. A second instance with a 4-bit
// counter exercises counter saturation.
module tb_dmem_arbiter;

   typedef struct {
      int          port;
      logic        isLoad;
      logic        err;
      logic [31:0] rdata;
      int          expCyc;
   } exp_t;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic [1:0]  req_i = '0;
   logic [1:0]  we_i = '0;
   logic [31:0] addr0_i = '0;
   logic [31:0] addr1_i = '0;
   logic [31:0] wdata0_i = '0;
   logic [31:0] wdata1_i = '0;
   logic [1:0]  gnt_o;
   logic [1:0]  rvalid_o;
   logic [31:0] rdata_o;
   logic        err_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_data_o;
   logic        mem_read_o;
   logic        mem_write_o;
   logic [31:0] mem_data_i;
   logic [15:0] acc_cnt_o;

   logic [1:0]  req4 = '0;
   logic [1:0]  zero2 = '0;
   logic [31:0] zero32 = '0;
   logic [1:0]  gnt4;
   logic [1:0]  rvalid4;
   logic [31:0] rdata4;
   logic        err4;
   logic [31:0] memAddr4;
   logic [31:0] memData4;
   logic        memRd4;
   logic        memWr4;
   logic [3:0]  cnt4;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          issuedCnt = 0;
   int          strobeCnt = 0;
   int          violations = 0;
   logic [31:0] mem [0:255];
   logic [31:0] expMem [0:255];
   logic        memReady = 1'b0;

   dmem_arbiter #(.MEM_BYTES(1024), .CNT_W(16)) u_dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .req_i       (req_i),
      .we_i        (we_i),
      .addr0_i     (addr0_i),
      .addr1_i     (addr1_i),
      .wdata0_i    (wdata0_i),
      .wdata1_i    (wdata1_i),
      .gnt_o       (gnt_o),
      .rvalid_o    (rvalid_o),
      .rdata_o     (rdata_o),
      .err_o       (err_o),
      .mem_addr_o  (mem_addr_o),
      .mem_data_o  (mem_data_o),
      .mem_read_o  (mem_read_o),
      .mem_write_o (mem_write_o),
      .mem_data_i  (mem_data_i),
      .acc_cnt_o   (acc_cnt_o)
   );

   dmem_arbiter #(.MEM_BYTES(1024), .CNT_W(4)) u_dut4 (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .req_i       (req4),
      .we_i        (zero2),
      .addr0_i     (zero32),
      .addr1_i     (zero32),
      .wdata0_i    (zero32),
      .wdata1_i    (zero32),
      .gnt_o       (gnt4),
      .rvalid_o    (rvalid4),
      .rdata_o     (rdata4),
      .err_o       (err4),
      .mem_addr_o  (memAddr4),
      .mem_data_o  (memData4),
      .mem_read_o  (memRd4),
      .mem_write_o (memWr4),
      .mem_data_i  (zero32),
      .acc_cnt_o   (cnt4)
   );

   always #5 clk_i = ~clk_i;

   // Free-running cycle counter used for latency expectations.
   always @(posedge clk_i) cyc <= cyc + 1;

   function automatic logic [31:0] initVal(input int i);
      return 32'hA500_0000 + 32'(i);
   endfunction

   function automatic logic addrErr(input logic [31:0] a);
      return (a[1:0] != 2'b00) || (a > 32'd1020);
   endfunction

   function automatic logic [1:0] oneHot(input int p);
      return (p == 1) ? 2'b10 : 2'b01;
   endfunction

   // Memory model: preloaded once, asynchronous read, write on the clock edge.
   always @(posedge clk_i) begin
      if (!memReady) begin
         for (int i = 0; i < 256; i++) mem[i] <= initVal(i);
         memReady <= 1'b1;
      end else if (mem_write_o) begin
         mem[mem_addr_o[9:2]] <= mem_data_o;
      end
   end

   assign mem_data_i = mem[mem_addr_o[9:2]];

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
      end
   endtask

   // Completion monitor: pops the scoreboard on each rvalid pulse and tracks invariants.
   always @(negedge clk_i) begin
      exp_t e;
      if (rst_i) begin
         if ($countones(gnt_o) > 1 || $countones(rvalid_o) > 1) violations++;
         if (err_o && rvalid_o == 2'b00) violations++;
         if (mem_read_o && mem_write_o) violations++;
         if ($countones(gnt4) > 1 || $countones(rvalid4) > 1 || (err4 && rvalid4 == 2'b00)) violations++;
         if (mem_read_o || mem_write_o) strobeCnt++;
         if (rvalid_o != 2'b00) begin
            if (sb.size() == 0) begin
               checkOutput("sbUnderflow", {30'b0, rvalid_o}, 32'd0);
            end else begin
               e = sb.pop_front();
               checkOutput("rvalidPort", {30'b0, rvalid_o}, {30'b0, oneHot(e.port)});
               checkOutput("errFlag", {31'b0, err_o}, {31'b0, e.err});
               if (e.isLoad || e.err) checkOutput("rdata", rdata_o, e.rdata);
               checkOutput("rvalidCycle", 32'(cyc), 32'(e.expCyc));
            end
         end
      end
   end

   task automatic setPort(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
      req_i[p] = 1'b1;
      we_i[p]  = we;
      if (p == 0) begin
         addr0_i  = a;
         wdata0_i = d;
      end else begin
         addr1_i  = a;
         wdata1_i = d;
      end
   endtask

   task automatic pushExp(input int p, input logic we, input logic [31:0] a, input logic [31:0] d, input int expCyc);
      exp_t e;
      e.port   = p;
      e.isLoad = !we;
      e.err    = addrErr(a);
      e.rdata  = (e.err || we) ? 32'd0 : expMem[a[9:2]];
      e.expCyc = expCyc;
      if (we && !e.err) expMem[a[9:2]] = d;
      sb.push_back(e);
      issuedCnt++;
   endtask

   task automatic applyStimulus(input int p, input logic we, input logic [31:0] a, input logic [31:0] d, input int lat);
      setPort(p, we, a, d);
      pushExp(p, we, a, d, cyc + lat);
   endtask

   task automatic waitGnt(input int p, output int seen);
      seen = -1;
      for (int i = 0; i < 8 && seen < 0; i++) begin
         @(negedge clk_i);
         if (gnt_o[p]) seen = cyc;
      end
      if (seen < 0) checkOutput("gntTimeout", {30'b0, gnt_o}, {30'b0, oneHot(p)});
   endtask

   task automatic singleAccess(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
      int c0;
      int g;
      logic [1:0] strobe;
      @(posedge clk_i);
      #1;
      c0 = cyc;
      applyStimulus(p, we, a, d, 2);
      waitGnt(p, g);
      req_i[p] = 1'b0;
      if (g >= 0) begin
         checkOutput("gntLatency", 32'(g), 32'(c0 + 1));
         strobe = addrErr(a) ? 2'b00 : (we ? 2'b01 : 2'b10);
         checkOutput("memStrobe", {30'b0, mem_read_o, mem_write_o}, {30'b0, strobe});
         if (!addrErr(a)) checkOutput("memAddr", mem_addr_o, a);
      end
   endtask

   task automatic checkAllZero();
      checkOutput("rstCtl", {25'b0, gnt_o, rvalid_o, err_o, mem_read_o, mem_write_o}, 32'd0);
      checkOutput("rstCnt", {16'b0, acc_cnt_o}, 32'd0);
      checkOutput("rstRdata", rdata_o, 32'd0);
      checkOutput("rstMemAddr", mem_addr_o, 32'd0);
      checkOutput("rstMemData", mem_data_o, 32'd0);
   endtask

   task automatic settle(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   initial begin
      int k;
      int c;
      int g;
      int g1;
      int s0;
      int found;
      for (int i = 0; i < 256; i++) expMem[i] = initVal(i);

      // Reset state.
      rst_i = 1'b0;
      settle(2);
      checkAllZero();
      rst_i = 1'b1;

      // Counter saturation on the 4-bit instance: 17 back-to-back accesses.
      @(posedge clk_i);
      #1;
      req4 = 2'b01;
      for (int i = 1; i <= 17; i++) begin
         found = 0;
         for (int w = 0; w < 10 && found == 0; w++) begin
            @(negedge clk_i);
            if (rvalid4 != 2'b00) found = 1;
         end
         if (found == 0) checkOutput("cntTimeout", {30'b0, rvalid4}, 32'd1);
         @(negedge clk_i);
         checkOutput("cntSat", {28'b0, cnt4}, (i > 15) ? 32'd15 : 32'(i));
      end
      req4 = 2'b00;
      settle(4);
      checkOutput("cntHold", {28'b0, cnt4}, 32'd15);

      // Both ports request continuously: grants alternate starting with port 0.
      @(posedge clk_i);
      #1;
      k = cyc;
      setPort(0, 1'b1, 32'h100, 32'hC0DE_0000);
      setPort(1, 1'b0, 32'h100, 32'd0);
      for (int i = 0; i < 8; i++) begin
         pushExp(i % 2, (i % 2) == 0, 32'h100 + 32'(4 * (i / 2)), 32'hC0DE_0000 + 32'(i / 2), k + 2 + 2 * i);
      end
      for (int i = 0; i < 8; i++) begin
         int j;
         int p;
         found = 0;
         for (int w = 0; w < 6 && found == 0; w++) begin
            @(negedge clk_i);
            if (gnt_o != 2'b00) found = 1;
         end
         checkOutput("rrGrant", {30'b0, gnt_o}, {30'b0, oneHot(i % 2)});
         checkOutput("rrGntCycle", 32'(cyc), 32'(k + 1 + 2 * i));
         p = i % 2;
         j = i / 2 + 1;
         if (j < 4) setPort(p, p == 0, 32'h100 + 32'(4 * j), 32'hC0DE_0000 + 32'(j));
         else req_i[p] = 1'b0;
      end
      settle(3);
      checkOutput("accCnt8", {16'b0, acc_cnt_o}, 32'(issuedCnt));

      // Port 0 store then load of the same word.
      singleAccess(0, 1'b1, 32'h10, 32'hDEAD_BEEF);
      singleAccess(0, 1'b0, 32'h10, 32'd0);

      // Error accesses never strobe memory but are still counted.
      settle(2);
      s0 = strobeCnt;
      singleAccess(1, 1'b0, 32'h13, 32'd0);
      singleAccess(1, 1'b0, 32'h3FE, 32'd0);
      singleAccess(1, 1'b1, 32'h400, 32'h5555_5555);
      settle(3);
      checkOutput("errNoStrobe", 32'(strobeCnt - s0), 32'd0);
      checkOutput("accCntErr", {16'b0, acc_cnt_o}, 32'(issuedCnt));
      singleAccess(1, 1'b0, 32'h3FC, 32'd0);

      // Port 1 requests while port 0 is in ACCESS and is granted out of RESP.
      @(posedge clk_i);
      #1;
      c = cyc;
      applyStimulus(0, 1'b1, 32'h30, 32'hAAAA_5555, 2);
      waitGnt(0, g);
      req_i[0] = 1'b0;
      applyStimulus(1, 1'b0, 32'h30, 32'd0, 3);
      waitGnt(1, g1);
      req_i[1] = 1'b0;
      checkOutput("gntInResp", 32'(g1), 32'(c + 3));
      settle(3);

      // Reset in the middle of a store: the store must not reach memory.
      @(posedge clk_i);
      #1;
      setPort(0, 1'b1, 32'h20, 32'h1234_5678);
      waitGnt(0, g);
      checkOutput("midStoreWr", {31'b0, mem_write_o}, 32'd1);
      #1;
      rst_i = 1'b0;
      req_i = 2'b00;
      issuedCnt = 0;
      #1;
      checkAllZero();
      @(posedge clk_i);
      #1;
      checkOutput("memUnchanged", mem[8], expMem[8]);
      @(negedge clk_i);
      rst_i = 1'b1;

      // First access after reset is granted on the first qualifying edge.
      singleAccess(0, 1'b0, 32'h20, 32'd0);
      settle(3);
      checkOutput("accCntPostRst", {16'b0, acc_cnt_o}, 32'(issuedCnt));
      checkOutput("sbEmpty", 32'(sb.size()), 32'd0);
      checkOutput("invariants", 32'(violations), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
